// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit shift stage. Pops one byte from the transmit holding
//   register and frames it as start / 5-8 data bits LSB-first / optional
//   parity / 1, 1.5 or 2 stop bits. Bit timing is derived from br_ce, which
//   pulses OS times per bit time.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   br_ce         baud enable, one clk wide, OS pulses per bit time
//   thr_d         byte presented by the holding register
//   thr_valid     holding register holds an unsent byte
//   thr_rd        one-cycle pop strobe back to the holding register
//   word_len      00=5, 01=6, 10=7, 11=8 data bits
//   stop2         2 stop bits (1.5 when word_len=00)
//   parity_en     append a parity bit
//   parity_even   1 = even, 0 = odd parity
//   parity_stick  parity bit forced to ~parity_even
//   break_ctl     force sout low without disturbing the frame timing
//   sout          serial output, idle high
//   tsr_empty     high while no frame is in progress
module uart_tx_serializer #(
    parameter int OS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       br_ce,
    input  logic [7:0] thr_d,
    input  logic       thr_valid,
    output logic       thr_rd,
    input  logic [1:0] word_len,
    input  logic       stop2,
    input  logic       parity_en,
    input  logic       parity_even,
    input  logic       parity_stick,
    input  logic       break_ctl,
    output logic       sout,
    output logic       tsr_empty
);

    // One extra bit so the tick counter can also time a 2-bit stop period.
    localparam int TW = $clog2(OS) + 1;
    localparam logic [TW-1:0] BIT_LAST   = TW'(OS - 1);
    localparam logic [TW-1:0] STOP1_LAST = TW'(OS - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OS / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bit;
    logic [2:0]      r_bit_last;
    logic [7:0]      r_shift;
    logic            r_par_en;
    logic            r_par_bit;
    logic [TW-1:0]   r_stop_last;
    logic            r_line;       // FSM line level before break forcing
    logic            r_sout;
    logic            r_thr_rd;
    logic            r_tsr_empty;

    logic [7:0]      w_mask;
    logic            w_par_calc;
    logic [TW-1:0]   w_stop_calc;
    logic [TW-1:0]   w_tick_last;
    logic            w_bit_end;
    logic            w_load;

    // Parity is taken from the byte masked to the configured word length.
    assign w_mask      = 8'hFF >> (2'd3 - word_len);
    assign w_par_calc  = parity_stick ? ~parity_even
                                      : (^(thr_d & w_mask)) ^ ~parity_even;
    assign w_stop_calc = !stop2            ? STOP1_LAST  :
                         (word_len == 2'b00) ? STOP15_LAST : STOP2_LAST;

    assign w_tick_last = (r_state == S_STOP) ? r_stop_last : BIT_LAST;
    assign w_bit_end   = br_ce && (r_tick == w_tick_last);

    // A load happens from IDLE, or at the last stop tick so back-to-back
    // frames have no idle gap.
    assign w_load = thr_valid &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    // NOTE: every register here is assigned with <= so all updates in this
    // block see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_bit_last  <= '0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop_last <= '0;
            r_line      <= 1'b1;
            r_sout      <= 1'b1;
            r_thr_rd    <= 1'b0;
            r_tsr_empty <= 1'b1;
        end else begin
            r_thr_rd <= 1'b0;
            // Break overrides the line without touching the FSM; later
            // assignments in this block replace this default on transitions.
            r_sout   <= r_line & ~break_ctl;

            if (w_load) begin
                r_shift     <= thr_d;
                r_thr_rd    <= 1'b1;
                r_bit_last  <= 3'(word_len) + 3'd4;
                r_par_en    <= parity_en;
                r_par_bit   <= w_par_calc;
                r_stop_last <= w_stop_calc;
                r_tick      <= '0;
                r_bit       <= '0;
                r_state     <= S_START;
                r_line      <= 1'b0;
                r_sout      <= 1'b0;
                r_tsr_empty <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (br_ce) begin
                    r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
                end

                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_state <= S_DATA;
                            r_line  <= r_shift[0];
                            r_sout  <= r_shift[0] & ~break_ctl;
                        end
                        S_DATA: begin
                            r_shift <= r_shift >> 1;
                            if (r_bit == r_bit_last) begin
                                r_bit <= '0;
                                if (r_par_en) begin
                                    r_state <= S_PARITY;
                                    r_line  <= r_par_bit;
                                    r_sout  <= r_par_bit & ~break_ctl;
                                end else begin
                                    r_state <= S_STOP;
                                    r_line  <= 1'b1;
                                    r_sout  <= ~break_ctl;
                                end
                            end else begin
                                r_bit  <= r_bit + 1'b1;
                                r_line <= r_shift[1];
                                r_sout <= r_shift[1] & ~break_ctl;
                            end
                        end
                        S_PARITY: begin
                            r_state <= S_STOP;
                            r_line  <= 1'b1;
                            r_sout  <= ~break_ctl;
                        end
                        S_STOP: begin
                            r_state     <= S_IDLE;
                            r_line      <= 1'b1;
                            r_sout      <= ~break_ctl;
                            r_tsr_empty <= 1'b1;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign thr_rd    = r_thr_rd;
    assign sout      = r_sout;
    assign tsr_empty = r_tsr_empty;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit shift stage. Sits directly downstream of the transmit holding register (8-bit clock-enabled register) and the baud generator.
- Pops one byte from the holding register and frames it as start / 5-8 data bits LSB-first / optional parity / 1, 1.5 or 2 stop bits.
- Drives the serial output pin and reports transmitter-empty status to the line status logic.

Parameters:
- OS, 16, br_ce pulses per bit time (oversample ratio); must be a power of 2, minimum 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- br_ce  in  1  baud enable, one clk-wide pulse per 1/OS bit time
- thr_d  in  8  holding register output (byte to send)
- thr_valid  in  1  holding register contains an unsent byte
- thr_rd  out  1  one-cycle pop strobe; holding register marks the byte consumed
- word_len  in  2  00=5, 01=6, 10=7, 11=8 data bits
- stop2  in  1  0 = 1 stop bit; 1 = 2 stop bits, or 1.5 when word_len=00
- parity_en  in  1  parity bit enable
- parity_even  in  1  1 = even parity, 0 = odd parity
- parity_stick  in  1  stick parity: bit = ~parity_even
- break_ctl  in  1  force sout low
- sout  out  1  serial data out, idle high
- tsr_empty  out  1  high when no frame is in progress

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, sout=1, thr_rd=0, tsr_empty=1, tick counter=0, bit counter=0, shift register=0. Deassertion is synchronous to clk.
- States:
  - IDLE
  - START
  - DATA
  - PARITY
  - STOP (length in ticks computed at load)
- IDLE:
  - On any clk edge with thr_valid=1: latch thr_d into the shift register, pulse thr_rd for exactly 1 cycle, latch word_len, stop2 and parity config, clear the tick counter, go to START.
  - The load does not wait for br_ce.
- Config latching: frame format is sampled only at load. Changes mid-frame take effect on the next frame.
- Tick counter: increments only on br_ce. A bit ends on the br_ce that brings the counter to OS-1. The counter then wraps to 0.
- Bit durations: start, each data bit and parity bit = OS ticks each.
- Stop duration:
  - OS ticks when stop2=0.
  - 2*OS when stop2=1 and word_len!=00.
  - 3*OS/2 when stop2=1 and word_len=00.
- START: sout=0 for one bit time, then DATA.
- DATA:
  - sout = shift register bit 0; shift right at each bit end.
  - Bit counter runs 0..N-1 where N = word_len+5.
  - After bit N-1: go to PARITY if the latched parity_en=1, else STOP.
- Parity bit value:
  - Non-stick: XOR of the N data bits, inverted when parity_even=0.
  - Stick: ~parity_even.
  - Computed from the latched byte masked to N bits, before shifting.
- STOP:
  - sout=1 for the stop duration.
  - At the end, if thr_valid=1 in that same cycle: load the next byte (thr_rd pulse), go directly to START, tsr_empty stays 0, no idle gap.
  - Otherwise go to IDLE.
- tsr_empty: 1 exactly when state=IDLE. It is registered and falls the cycle after the load edge.
- Latency: sout falls on the clk edge after the thr_valid sample, i.e. in the same edge that asserts thr_rd.
- break_ctl: sout=0 whenever break_ctl=1. The FSM and counters continue unaffected, and the frame completes normally underneath. sout returns to the FSM value the cycle after break_ctl falls.
- br_ce held high continuously is legal: one tick per clk.
- br_ce coinciding with the load cycle is not counted toward the start bit.
- thr_rd is never asserted outside the load cycle. It is never asserted twice for one byte.
- thr_valid dropping mid-frame has no effect on the frame in flight.
- Reset mid-frame: immediate abort, sout=1, no thr_rd. The interrupted byte is lost.
- All outputs are registered (sout, thr_rd, tsr_empty) and glitch-free.

Test Plan:
- 8N1, OS=16, br_ce every 4 clk, thr_d=0x55 -> one thr_rd pulse; sout = 0,1,0,1,0,1,0,1,0,1, each level 64 clk long; tsr_empty rises after 640 clk.
- 7E1, thr_d=0xA3 (7-bit 0x23, three ones) -> data 1,1,0,0,0,1,0 then parity 1, then stop; total 10 bit times.
- 5 bits, stop2=1, thr_d=0x1F -> stop high for 24 ticks; 6O with stick, parity_even=1 -> parity bit 0.
- Back-to-back: thr_valid held high with 0x01 then 0x80 -> second start bit begins immediately after the first frame's stop bit, no extra idle tick; tsr_empty never rises between frames; exactly 2 thr_rd pulses.
- break_ctl=1 mid data bit 3 for 20 ticks -> sout=0 throughout; frame timing unchanged; tsr_empty rises at the nominal frame end.
- rst_n=0 during DATA -> sout=1, tsr_empty=1 asynchronously; after release with thr_valid=0 the block stays IDLE with sout=1.
